// File: rtl/byte_lane_dly_seq.sv
// Delay-table sequencer: holds IDELAY/ODELAY values for every byte lane and streams them out on apply.
// Optional BYTE_LANE_DLY_DIRTY_EN: only entries written since their last load are strobed.
module byte_lane_dly_seq #(
  parameter int NUM_LANES = 2,
  parameter int DQ_WIDTH  = 8,
  parameter int DLY_W     = 8,
  parameter int LANE_W    = 3
) (
  input  logic                 clk_div,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [LANE_W-1:0]    wr_lane,
  input  logic [4:0]           wr_addr,
  input  logic [DLY_W-1:0]     wr_data,
  input  logic                 apply,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err,
  output logic [DLY_W-1:0]     lane_dly_data,
  output logic [4:0]           lane_dly_addr,
  output logic [NUM_LANES-1:0] lane_ld_delay,
  output logic                 lane_set
);

  // state  | meaning
  // S_IDLE | waiting for apply
  // S_LOAD | reading one table entry per cycle
  // S_SET  | last entry on the bus, lane_set issued next
  // S_DONE | lane_set on the bus, done issued next
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SET, S_DONE} state_t;

  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IDX_W = LW + 5;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] O_LAST = 4'(DQ_WIDTH + 1);
  localparam logic [3:0] I_LAST = 4'(DQ_WIDTH);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

  state_t            state;
  logic [DLY_W-1:0]  tbl [DEPTH];
  logic [LANE_W-1:0] rd_lane;
  logic [4:0]        rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_lane_ok;
  logic              wr_ok;
  logic              strobe_en;
  logic              apply_err;

  assign wr_lane_ok = {1'b0, wr_lane} < (LANE_W + 1)'(NUM_LANES);
  assign wr_ok      = wr_lane_ok && (wr_addr[4] ? (wr_addr[3:0] <= I_LAST)
                                                : (wr_addr[3:0] <= O_LAST));
  assign wr_idx     = {wr_lane[LW-1:0], wr_addr};
  assign rd_idx     = {rd_lane[LW-1:0], rd_addr};
  assign apply_err  = apply && (state == S_LOAD || state == S_SET);

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en && wr_ok) begin
      tbl[wr_idx] <= wr_data;
    end
  end

`ifdef BYTE_LANE_DLY_DIRTY_EN
  logic [DEPTH-1:0] dirty;

  // Clear on read first so a colliding write keeps the entry dirty.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '1;
    end else begin
      if (state == S_LOAD) dirty[rd_idx] <= 1'b0;
      if (wr_en && wr_ok) dirty[wr_idx] <= 1'b1;
    end
  end

  assign strobe_en = dirty[rd_idx];
`else
  assign strobe_en = 1'b1;
`endif

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      err[0] <= (wr_en && !wr_ok) || (err[0] && !clr_err);
      err[1] <= apply_err || (err[1] && !clr_err);
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      lane_dly_data <= '0;
      lane_dly_addr <= '0;
      lane_ld_delay <= '0;
      lane_set      <= 1'b0;
      rd_lane       <= '0;
      rd_addr       <= '0;
    end else begin
      done          <= 1'b0;
      lane_ld_delay <= '0;
      lane_set      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (apply) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            rd_lane <= '0;
            rd_addr <= '0;
          end
        end
        S_LOAD: begin
          lane_dly_data <= tbl[rd_idx];
          lane_dly_addr <= rd_addr;
          if (strobe_en) lane_ld_delay <= NUM_LANES'(1) << rd_lane;
          if (rd_addr == {1'b1, I_LAST}) begin
            rd_addr <= '0;
            rd_lane <= rd_lane + LANE_W'(1);
            if (rd_lane == LANE_LAST) state <= S_SET;
          end else if (rd_addr == {1'b0, O_LAST}) begin
            rd_addr <= 5'h10;
          end else begin
            rd_addr <= rd_addr + 5'd1;
          end
        end
        S_SET: begin
          lane_set <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_lane_dly_seq.sv
// Directed bench for byte_lane_dly_seq (NUM_LANES=2, DQ_WIDTH=8): write/err vector table plus full-pass checks.
module tb_byte_lane_dly_seq;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_lane = '0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       apply = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy, done, lane_set;
  logic [1:0] err;
  logic [7:0] lane_dly_data;
  logic [4:0] lane_dly_addr;
  logic [1:0] lane_ld_delay;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_tbl   [2][32];
  bit         m_dirty [2][32];
  logic [4:0] hold_addr = '0;
  logic [7:0] hold_data = '0;

  byte_lane_dly_seq #(.NUM_LANES(2), .DQ_WIDTH(8), .DLY_W(8), .LANE_W(3)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .wr_en(wr_en), .wr_lane(wr_lane),
    .wr_addr(wr_addr), .wr_data(wr_data), .apply(apply), .clr_err(clr_err),
    .busy(busy), .done(done), .err(err), .lane_dly_data(lane_dly_data),
    .lane_dly_addr(lane_dly_addr), .lane_ld_delay(lane_ld_delay), .lane_set(lane_set)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    logic       wr_en;
    logic [2:0] lane;
    logic [4:0] addr;
    logic [7:0] data;
    logic       clr;
    logic       stores;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk_div);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++)
      for (int a = 0; a < 32; a++) begin
        m_tbl[l][a] = '0;
        m_dirty[l][a] = 1'b1;
      end
    hold_addr = '0;
    hold_data = '0;
  endtask

  task automatic wr_one(input int l, input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_lane = 3'(l); wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    m_tbl[l][a] = d;
    m_dirty[l][a] = 1'b1;
  endtask

  // One full pass. inj_apply: cycle to pulse apply; inj_wr: cycle to write table[0][0]=8'h11.
  task automatic do_pass(input int inj_apply, input int inj_wr);
    logic [17:0] exp_v [43];
    logic [4:0]  a;
    logic        strobe;
    int          k;
    k = 0;
    for (int c = 0; c < 43; c++)
      exp_v[c] = {(c >= 1 && c <= 40), (c == 41), (c == 40), 2'b00, hold_addr, hold_data};
    for (int l = 0; l < 2; l++)
      for (int e = 0; e < 19; e++) begin
        a = (e < 10) ? 5'(e) : 5'(16 + e - 10);
`ifdef BYTE_LANE_DLY_DIRTY_EN
        strobe = m_dirty[l][a];
`else
        strobe = 1'b1;
`endif
        hold_addr = a;
        hold_data = m_tbl[l][a];
        exp_v[2 + k] = {1'b1, 1'b0, 1'b0, strobe ? 2'(1 << l) : 2'b00, a, m_tbl[l][a]};
        for (int c = 3 + k; c < 43; c++) exp_v[c][12:0] = {a, m_tbl[l][a]};
        k++;
      end
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 32; i++) m_dirty[l][i] = 1'b0;
    apply = 1'b1;
    step();
    apply = 1'b0;
    for (int c = 1; c < 43; c++) begin
      check($sformatf("pass_c%0d", c),
            32'({busy, done, lane_set, lane_ld_delay, lane_dly_addr, lane_dly_data}), 32'(exp_v[c]));
      if (c == inj_apply) apply = 1'b1;
      if (c == inj_wr) begin
        wr_en = 1'b1; wr_lane = 3'd0; wr_addr = 5'h00; wr_data = 8'h11;
        m_tbl[0][0] = 8'h11;
        m_dirty[0][0] = 1'b1;
      end
      step();
      apply = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin
    //          wr_en lane addr   data   clr  stores exp_err
    vecs[0] = '{1'b1, 3'd1, 5'h12, 8'hA7, 1'b0, 1'b1, 2'b00};
    vecs[1] = '{1'b1, 3'd0, 5'h1A, 8'h33, 1'b0, 1'b0, 2'b01};
    vecs[2] = '{1'b0, 3'd0, 5'h00, 8'h00, 1'b1, 1'b0, 2'b00};
    vecs[3] = '{1'b1, 3'd2, 5'h00, 8'h44, 1'b0, 1'b0, 2'b01};
    vecs[4] = '{1'b1, 3'd0, 5'h0A, 8'h45, 1'b1, 1'b0, 2'b01};
    vecs[5] = '{1'b0, 3'd0, 5'h00, 8'h00, 1'b1, 1'b0, 2'b00};
    vecs[6] = '{1'b1, 3'd0, 5'h09, 8'h5C, 1'b0, 1'b1, 2'b00};
    vecs[7] = '{1'b1, 3'd0, 5'h18, 8'h6D, 1'b0, 1'b1, 2'b00};
    vecs[8] = '{1'b1, 3'd1, 5'h19, 8'h77, 1'b0, 1'b0, 2'b01};
    vecs[9] = '{1'b0, 3'd0, 5'h00, 8'h00, 1'b1, 1'b0, 2'b00};

    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ld", 32'(lane_ld_delay), 32'd0);
    check("rst_set", 32'(lane_set), 32'd0);
    check("rst_data", 32'(lane_dly_data), 32'd0);
    check("rst_addr", 32'(lane_dly_addr), 32'd0);

    for (int i = 0; i < 10; i++) begin
      wr_en = vecs[i].wr_en; wr_lane = vecs[i].lane; wr_addr = vecs[i].addr;
      wr_data = vecs[i].data; clr_err = vecs[i].clr;
      step();
      wr_en = 1'b0; clr_err = 1'b0;
      if (vecs[i].stores) begin
        m_tbl[vecs[i].lane][vecs[i].addr] = vecs[i].data;
        m_dirty[vecs[i].lane][vecs[i].addr] = 1'b1;
      end
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    do_pass(-1, -1);
    check("err_after_pass", 32'(err), 32'd0);

    do_pass(10, -1);
    check("apply_busy_err", 32'(err), 32'd2);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("apply_err_clr", 32'(err), 32'd0);

    do_pass(40, -1);
    check("apply_done_noerr", 32'(err), 32'd0);

    do_pass(-1, 1);
    do_pass(-1, -1);

    wr_one(0, 5'h03, 8'h55);
    do_pass(-1, -1);

    apply = 1'b1;
    step();
    apply = 1'b0;
    repeat (5) step();
    check("midload_ld", 32'(lane_ld_delay), 32'd1);
    rst_n = 1'b0;
    model_reset();
    step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ld", 32'(lane_ld_delay), 32'd0);
    rst_n = 1'b1;
    step();
    do_pass(-1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
